// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane store masks and a fixed-latency
// request/response handshake: IDLE accepts, WAIT counts down, RESP pulses data_valid.
module data_memory #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int Latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 request,
  input  logic                 we_re,
  input  logic [3:0]           mask,
  input  logic [DataWidth-1:0] address,
  input  logic [DataWidth-1:0] store_data,
  output logic                 ready,
  output logic                 data_valid,
  output logic [DataWidth-1:0] load_data,
  output logic                 stall
);

  localparam int IdxW = $clog2(Depth);
  localparam logic [3:0] CntInit = (Latency > 1) ? 4'(Latency - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DataWidth-1:0]  load_data_q, load_data_d;
  logic [DataWidth-1:0]  mem [Depth];
  logic [IdxW-1:0]       idx;
  logic                  accept;

  // Byte offset and bits above the word index are dropped, so addresses wrap modulo Depth.
  assign idx    = address[IdxW+1:2];
  assign accept = request && (state_q == IDLE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[DataWidth-1:IdxW+2], address[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      load_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (Latency == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The load word is captured at acceptance and held until the next accepted load.
  always_comb begin
    load_data_d = load_data_q;
    if (accept && !we_re) load_data_d = mem[idx];
  end

  // NOTE: the array has no reset; clearing a RAM would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (accept && we_re) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    ready      = (state_q == IDLE);
    data_valid = (state_q == RESP);
    stall      = request && !data_valid;
    load_data  = load_data_q;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DataWidth, default 32, data and address width in bits.
REQ-002 Parameter Depth, default 1024, number of DataWidth-bit words stored; SHALL be a power of two.
REQ-003 Parameter Latency, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 request  input  1  memory operation requested (load or store), level, held by requester until data_valid.
REQ-007 we_re  input  1  1 = store, 0 = load; sampled at acceptance.
REQ-008 mask  input  4  byte-lane write enables for stores; bit i enables byte i (bits 8i+7:8i).
REQ-009 address  input  DataWidth  byte address; word index = address[log2(Depth)+1:2].
REQ-010 store_data  input  DataWidth  lane-aligned store data.
REQ-011 ready  output  1  block can accept a request this cycle.
REQ-012 data_valid  output  1  one-cycle response pulse for the accepted operation.
REQ-013 load_data  output  DataWidth  full word read for a load; valid when data_valid=1 and the operation was a load.
REQ-014 stall  output  1  pipeline hold: request=1 and data_valid=0.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-016 Acceptance SHALL occur in a cycle T where request=1 and ready=1; request in WAIT or RESP SHALL be ignored, never queued.
REQ-017 On acceptance: Latency=1 -> next state RESP; Latency>1 -> WAIT with counter loaded to Latency-2.
REQ-018 In WAIT the counter SHALL decrement each cycle; at counter=0 next state RESP.
REQ-019 RESP SHALL last exactly one cycle with data_valid=1, then IDLE unconditionally.
REQ-020 data_valid SHALL be 1 in cycle T+Latency only; consecutive accepted operations are spaced at least Latency+1 cycles.
REQ-021 Store: at the acceptance edge, for each mask bit set, the word at the index SHALL have that byte replaced by the same byte of store_data; unmasked bytes unchanged.
REQ-022 Store with mask=0000 SHALL leave memory unchanged but complete the full handshake.
REQ-023 Load: the addressed word SHALL be captured at the acceptance edge into a register driven on load_data; mask ignored.
REQ-024 load_data SHALL hold its last value outside load responses; stores SHALL NOT modify load_data.
REQ-025 A load accepted after a completed store to the same word SHALL return the updated word.
REQ-026 Address bits above the index SHALL be ignored (wrap-around modulo Depth words); address[1:0] ignored.
REQ-027 stall SHALL be combinational from request and data_valid only.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, data_valid=0, load_data=0, ready=1 after release.
REQ-029 Memory array SHALL NOT be reset; contents undefined until written.
REQ-030 Reset during WAIT/RESP SHALL abandon the response (no data_valid); a store already written at acceptance remains in memory.
REQ-031 First acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-032 Latency=2: store addr 0x10, data 0xDEADBEEF, mask 1111 at T -> data_valid=1 at T+2 only; ready=0 at T+1, T+2.
REQ-033 Then load addr 0x10 -> load_data=0xDEADBEEF with data_valid at acceptance+2; stall=1 until that cycle.
REQ-034 Store addr 0x10, data 0x000000AA, mask 0001 over 0xDEADBEEF -> later load returns 0xDEADBEAA; mask 0000 store -> word unchanged, data_valid still pulses.
REQ-035 Depth=1024: store 0x12345678 to addr 0x0000_0004, load addr 0x0000_1004 -> returns 0x12345678 (wrap).
REQ-036 Accept load, assert rst_n=0 at T+1 for one cycle -> no data_valid; load_data=0; ready=1 after release; next load completes normally.
REQ-037 Latency=1 back-to-back requests held high -> data_valid every 2nd cycle, exactly one pulse per accepted operation.
